// File: rtl/lc3b_types.sv
// Shared types and sizing for the BTB update controller.
package lc3b_types;

  localparam int BTB_INDEX_BITS = 4;
  localparam int BTB_TAG_BITS   = 12;
  localparam int BTB_MAX_DEFER  = 3;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] target;
    logic        uc;
  } btb_update_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/btb_update_fifo.sv
// Two-entry BTB update FIFO with tail coalescing and drop-on-full.
// FSM state is the occupancy: EMPTY, ONE, FULL.
module btb_update_fifo
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  btb_update_t upd,
  output logic        head_valid,
  output btb_update_t head,
  output logic        drop
);

  fifo_state_t state, next_state;
  btb_update_t mem [2];
  logic        hd;
  logic        tail_idx;
  logic        wr_idx;
  logic        coalesce;
  logic        do_push;

  always_comb begin
    tail_idx   = (state == FULL) ? ~hd : hd;
    wr_idx     = (state == ONE) ? ~hd : hd;
    // A matching tail that is also the departing head cannot absorb the update.
    coalesce   = push && (state != EMPTY) && (mem[tail_idx].pc == upd.pc) &&
                 !((state == ONE) && pop);
    do_push    = push && !coalesce && ((state != FULL) || pop);
    drop       = push && !coalesce && (state == FULL) && !pop && !flush;
    head_valid = (state != EMPTY);
    head       = mem[hd];
    next_state = state;
    if (flush) begin
      next_state = EMPTY;
    end else if (do_push && !pop) begin
      next_state = (state == EMPTY) ? ONE : FULL;
    end else if (pop && !do_push) begin
      next_state = (state == FULL) ? ONE : EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      hd     <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      state <= next_state;
      if (!flush) begin
        if (pop)      hd            <= ~hd;
        if (coalesce) mem[tail_idx] <= upd;
        if (do_push)  mem[wr_idx]   <= upd;
      end
    end
  end

endmodule

// File: rtl/btb_ctrl.sv
// BTB update controller: queues mispredicted taken branches and writes them
// into the BTB, deferring while fetch reads the same index. Optional
// statistics outputs under BTB_CTRL_STATS_EN.
module btb_ctrl
  import lc3b_types::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      br_valid,
  input  logic                      br_taken,
  input  logic                      br_uc,
  input  logic [15:0]               br_pc,
  input  logic [15:0]               br_target,
  input  logic                      pred_hit,
  input  logic [15:0]               pred_target,
  input  logic                      fetch_valid,
  input  logic [BTB_INDEX_BITS-1:0] index_fetch,
  input  logic                      flush,
  output logic                      btb_write,
  output logic                      btb_uc,
  output logic [BTB_INDEX_BITS-1:0] index_mem,
  output logic [BTB_TAG_BITS-1:0]   tag_mem,
  output logic [15:0]               target,
  output logic                      drop_pulse
`ifdef BTB_CTRL_STATS_EN
  ,
  output logic [15:0]               upd_count,
  output logic [15:0]               drop_count
`endif
);

  logic        new_upd;
  logic        head_valid;
  logic        fifo_drop;
  logic        defer;
  logic [1:0]  defer_cnt;
  btb_update_t upd;
  btb_update_t head;

  assign new_upd = br_valid && br_taken && (!pred_hit || (pred_target != br_target));
  assign upd     = '{pc: br_pc, target: br_target, uc: br_uc};

  btb_update_fifo u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push       (new_upd),
    .pop        (btb_write),
    .upd        (upd),
    .head_valid (head_valid),
    .head       (head),
    .drop       (fifo_drop)
  );

  always_comb begin
    defer      = fetch_valid && (index_fetch == head.pc[BTB_INDEX_BITS-1:0]);
    btb_write  = head_valid && !reset &&
                 !(defer && (defer_cnt != 2'(BTB_MAX_DEFER)));
    drop_pulse = fifo_drop && !reset;
    btb_uc     = 1'b0;
    index_mem  = '0;
    tag_mem    = '0;
    target     = '0;
    if (head_valid && !reset) begin
      btb_uc    = head.uc;
      index_mem = head.pc[BTB_INDEX_BITS-1:0];
      tag_mem   = head.pc[15:BTB_INDEX_BITS];
      target    = head.target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush || btb_write) begin
      defer_cnt <= 2'd0;
    end else if (head_valid && defer) begin
      defer_cnt <= defer_cnt + 2'd1;
    end
  end

`ifdef BTB_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_count  <= '0;
      drop_count <= '0;
    end else begin
      if (btb_write && (upd_count != 16'hFFFF))   upd_count  <= upd_count + 16'd1;
      if (drop_pulse && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_btb_ctrl.sv
// Directed self-checking bench for btb_ctrl (stats checks under BTB_CTRL_STATS_EN).
module tb_btb_ctrl;

  logic        clk = 1'b0;
  logic        reset, br_valid, br_taken, br_uc, pred_hit, fetch_valid, flush;
  logic [15:0] br_pc, br_target, pred_target;
  logic [3:0]  index_fetch;
  logic        btb_write, btb_uc, drop_pulse;
  logic [3:0]  index_mem;
  logic [11:0] tag_mem;
  logic [15:0] target;
`ifdef BTB_CTRL_STATS_EN
  logic [15:0] upd_count, drop_count;
`endif

  int errors = 0;
  int checks = 0;

  btb_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .br_valid    (br_valid),
    .br_taken    (br_taken),
    .br_uc       (br_uc),
    .br_pc       (br_pc),
    .br_target   (br_target),
    .pred_hit    (pred_hit),
    .pred_target (pred_target),
    .fetch_valid (fetch_valid),
    .index_fetch (index_fetch),
    .flush       (flush),
    .btb_write   (btb_write),
    .btb_uc      (btb_uc),
    .index_mem   (index_mem),
    .tag_mem     (tag_mem),
    .target      (target),
    .drop_pulse  (drop_pulse)
`ifdef BTB_CTRL_STATS_EN
    ,
    .upd_count   (upd_count),
    .drop_count  (drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; checks run 1ns later.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic no_br();
    br_valid = 0; br_taken = 0; br_uc = 0; br_pc = 0; br_target = 0;
    pred_hit = 0; pred_target = 0;
  endtask

  task automatic br(input logic [15:0] pc, input logic [15:0] tgt, input logic uc);
    br_valid = 1; br_taken = 1; br_uc = uc; br_pc = pc; br_target = tgt;
    pred_hit = 0; pred_target = 0;
  endtask

  task automatic chk_wr(input string tag, input logic w, input logic [15:0] tgt);
    #1;
    chk({tag, ".write"}, btb_write, w);
    chk({tag, ".target"}, target, tgt);
  endtask

  initial begin
    reset = 1; flush = 0; fetch_valid = 0; index_fetch = 0;
    no_br();
    br(16'h1234, 16'h2000, 0);
    #1;
    chk("rst.write", btb_write, 0);
    chk("rst.drop", drop_pulse, 0);
    chk("rst.target", target, 0);
    tick(); tick();
    reset = 0; no_br();
    #1;
    chk("post_rst.write", btb_write, 0);
    chk("post_rst.index", index_mem, 0);
    chk("post_rst.tag", tag_mem, 0);
`ifdef BTB_CTRL_STATS_EN
    chk("rst.upd_count", upd_count, 0);
    chk("rst.drop_count", drop_count, 0);
`endif

    // taken miss, no conflict
    tick(); br(16'h1234, 16'h2000, 0);
    chk_wr("miss.same_cycle", 0, 16'h0000);
    tick(); no_br();
    chk_wr("miss.next", 1, 16'h2000);
    chk("miss.index", index_mem, 4'h4);
    chk("miss.tag", tag_mem, 12'h123);
    chk("miss.uc", btb_uc, 0);
    tick();
    chk_wr("miss.after_pop", 0, 16'h0000);
`ifdef BTB_CTRL_STATS_EN
    chk("miss.upd_count", upd_count, 1);
`endif

    // correct prediction and not-taken: no update
    tick(); br(16'h1234, 16'h2000, 0); pred_hit = 1; pred_target = 16'h2000;
    tick(); br(16'h1234, 16'h2000, 0); br_taken = 0;
    chk_wr("hit_ok.next", 0, 16'h0000);
    tick(); no_br();
    chk_wr("not_taken.next", 0, 16'h0000);

    // hit with wrong target, unconditional
    tick(); br(16'h0010, 16'h0050, 1); pred_hit = 1; pred_target = 16'h0040;
    tick(); no_br();
    chk_wr("hit_bad.next", 1, 16'h0050);
    chk("hit_bad.uc", btb_uc, 1);
    chk("hit_bad.index", index_mem, 4'h0);
    tick();

    // deferral: 3 deferred cycles, written on the 4th
    fetch_valid = 1; index_fetch = 4'h4;
    br(16'h1234, 16'h2222, 0);
    tick(); no_br();
    chk_wr("defer.c1", 0, 16'h2222);
    tick(); chk_wr("defer.c2", 0, 16'h2222);
    tick(); chk_wr("defer.c3", 0, 16'h2222);
    tick(); chk_wr("defer.c4", 1, 16'h2222);
    tick(); chk_wr("defer.c5", 0, 16'h0000);

    // three distinct updates while deferred: third dropped
    br(16'h1234, 16'hA000, 0);
    tick(); br(16'h2234, 16'hB000, 0);
    #1; chk("drop.c1_drop", drop_pulse, 0);
    tick(); br(16'h3234, 16'hC000, 0);
    #1; chk("drop.c2_drop", drop_pulse, 1);
    chk("drop.c2_write", btb_write, 0);
    tick(); no_br();
    #1; chk("drop.c3_drop", drop_pulse, 0);
    chk_wr("drop.c3", 0, 16'hA000);
    tick(); chk_wr("drop.c4", 1, 16'hA000);
    tick(); fetch_valid = 0;
    chk_wr("drop.c5", 1, 16'hB000);
    tick(); chk_wr("drop.c6", 0, 16'h0000);
`ifdef BTB_CTRL_STATS_EN
    chk("drop.drop_count", drop_count, 1);
`endif

    // coalescing while deferred
    fetch_valid = 1;
    br(16'h1234, 16'h3000, 0);
    tick(); br(16'h1234, 16'h3100, 0);
    #1; chk("coal.drop", drop_pulse, 0);
    chk_wr("coal.c1", 0, 16'h3000);
    tick(); no_br(); fetch_valid = 0;
    chk_wr("coal.c2", 1, 16'h3100);
    tick(); chk_wr("coal.c3", 0, 16'h0000);

    // same pc as head being popped: pushed, not coalesced
    br(16'h0100, 16'h0500, 0);
    tick(); br(16'h0100, 16'h0600, 0);
    chk_wr("pushpop.c1", 1, 16'h0500);
    tick(); no_br();
    chk_wr("pushpop.c2", 1, 16'h0600);
    tick(); chk_wr("pushpop.c3", 0, 16'h0000);

    // fill FULL, then flush with a new update
    fetch_valid = 1;
    br(16'h1234, 16'h4000, 0);
    tick(); br(16'h2234, 16'h4100, 0);
    tick(); br(16'h3234, 16'h4200, 0); flush = 1;
    tick(); no_br(); flush = 0; fetch_valid = 0;
    chk_wr("flush.c1", 0, 16'h0000);
    chk("flush.index", index_mem, 0);
    tick(); chk_wr("flush.c2", 0, 16'h0000);

    // reset mid-deferral discards pending update
    fetch_valid = 1;
    br(16'h1234, 16'h5000, 0);
    tick(); no_br();
    chk_wr("rst_mid.pending", 0, 16'h5000);
    reset = 1; flush = 1;
    tick(); reset = 0; flush = 0; fetch_valid = 0;
    chk_wr("rst_mid.after", 0, 16'h0000);
`ifdef BTB_CTRL_STATS_EN
    chk("rst_mid.upd_count", upd_count, 0);
    chk("rst_mid.drop_count", drop_count, 0);
`endif
    tick(); chk_wr("rst_mid.after2", 0, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
